// File: rtl/execute_pkg.sv
// Shared widths and select/opcode encodings for the EXE stage.
package execute_pkg;

  localparam int XLEN           = 32;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int A_SEL_WIDTH    = 3;
  localparam int B_SEL_WIDTH    = 3;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int SHAMT_WIDTH    = $clog2(XLEN);

  localparam logic [XLEN-1:0] B_CONST_FOUR = XLEN'(4);

  typedef enum logic [A_SEL_WIDTH-1:0] {
    A_SEL_RS1  = 3'd0,
    A_SEL_PC   = 3'd1,
    A_SEL_ALU  = 3'd2,
    A_SEL_MEM  = 3'd3,
    A_SEL_ZERO = 3'd4
  } a_sel_e;

  typedef enum logic [B_SEL_WIDTH-1:0] {
    B_SEL_RS2  = 3'd0,
    B_SEL_IMM  = 3'd1,
    B_SEL_FOUR = 3'd2,
    B_SEL_ALU  = 3'd3,
    B_SEL_MEM  = 3'd4,
    B_SEL_ZERO = 3'd5
  } b_sel_e;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD    = 4'd0,
    ALU_OP_SUB    = 4'd1,
    ALU_OP_SLL    = 4'd2,
    ALU_OP_SLT    = 4'd3,
    ALU_OP_SLTU   = 4'd4,
    ALU_OP_XOR    = 4'd5,
    ALU_OP_SRL    = 4'd6,
    ALU_OP_SRA    = 4'd7,
    ALU_OP_OR     = 4'd8,
    ALU_OP_AND    = 4'd9,
    ALU_OP_PASS_B = 4'd10
  } alu_op_e;

  // Shifts only ever look at the low log2(XLEN) bits of operand B.
  function automatic logic [SHAMT_WIDTH-1:0] shift_amount(input logic [XLEN-1:0] b);
    return b[SHAMT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/execute_if.sv
// ID/EXE operand bundle in, EXE/MEM pipeline registers out.
interface execute_if;
  import execute_pkg::*;

  logic [XLEN-1:0]           pc_exe;
  logic [REG_DATA_WIDTH-1:0] rs1_exe;
  logic [REG_DATA_WIDTH-1:0] rs2_exe;
  logic [XLEN-1:0]           instr_exe;
  logic [XLEN-1:0]           imm_exe;
  logic [A_SEL_WIDTH-1:0]    a_sel;
  logic [B_SEL_WIDTH-1:0]    b_sel;
  logic [ALU_OP_WIDTH-1:0]   alu_op;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_exe;
  logic [XLEN-1:0]           forward_mem;
  logic [XLEN-1:0]           forward_wb;

  logic [XLEN-1:0]           pc_mem;
  logic [XLEN-1:0]           alu_mem;
  logic [REG_DATA_WIDTH-1:0] rs2_mem;
  logic [XLEN-1:0]           instr_mem;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem;

  modport master (
    output pc_exe, rs1_exe, rs2_exe, instr_exe, imm_exe,
    output a_sel, b_sel, alu_op, rd_addr_exe, forward_mem, forward_wb,
    input  pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem
  );

  modport slave (
    input  pc_exe, rs1_exe, rs2_exe, instr_exe, imm_exe,
    input  a_sel, b_sel, alu_op, rd_addr_exe, forward_mem, forward_wb,
    output pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem
  );

endinterface

// File: rtl/execute_alu.sv
// Purely combinational integer ALU; unused opcodes produce zero.
module alu
  import execute_pkg::*;
(
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [XLEN-1:0]         result
);

  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic                   w_lt_signed;
  logic                   w_lt_unsigned;

  assign w_shamt       = shift_amount(b);
  assign w_lt_signed   = $signed(a) < $signed(b);
  assign w_lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_OP_ADD:    result = a + b;
      ALU_OP_SUB:    result = a - b;
      ALU_OP_SLL:    result = a << w_shamt;
      ALU_OP_SLT:    result = {{(XLEN-1){1'b0}}, w_lt_signed};
      ALU_OP_SLTU:   result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      ALU_OP_XOR:    result = a ^ b;
      ALU_OP_SRL:    result = a >> w_shamt;
      ALU_OP_SRA:    result = $unsigned($signed(a) >>> w_shamt);
      ALU_OP_OR:     result = a | b;
      ALU_OP_AND:    result = a & b;
      ALU_OP_PASS_B: result = b;
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// EXE stage: operand/forwarding muxes, ALU, and EXE/MEM pipeline registers.
module execute
  import execute_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave bus
);

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;

  logic [XLEN-1:0]           r_pc_mem;
  logic [XLEN-1:0]           r_alu_mem;
  logic [REG_DATA_WIDTH-1:0] r_rs2_mem;
  logic [XLEN-1:0]           r_instr_mem;
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr_mem;

  // Forwarding choice is made upstream; unassigned select codes give zero.
  always_comb begin
    w_op_a = '0;
    case (bus.a_sel)
      A_SEL_RS1:  w_op_a = bus.rs1_exe;
      A_SEL_PC:   w_op_a = bus.pc_exe;
      A_SEL_ALU:  w_op_a = bus.forward_mem;
      A_SEL_MEM:  w_op_a = bus.forward_wb;
      A_SEL_ZERO: w_op_a = '0;
      default:    w_op_a = '0;
    endcase
  end

  always_comb begin
    w_op_b = '0;
    case (bus.b_sel)
      B_SEL_RS2:  w_op_b = bus.rs2_exe;
      B_SEL_IMM:  w_op_b = bus.imm_exe;
      B_SEL_FOUR: w_op_b = B_CONST_FOUR;
      B_SEL_ALU:  w_op_b = bus.forward_mem;
      B_SEL_MEM:  w_op_b = bus.forward_wb;
      B_SEL_ZERO: w_op_b = '0;
      default:    w_op_b = '0;
    endcase
  end

  alu u_alu (
    .a      (w_op_a),
    .b      (w_op_b),
    .alu_op (bus.alu_op),
    .result (w_alu_result)
  );

  // No stall or flush: every edge out of reset captures the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_mem      <= '0;
      r_alu_mem     <= '0;
      r_rs2_mem     <= '0;
      r_instr_mem   <= '0;
      r_rd_addr_mem <= '0;
    end else begin
      r_pc_mem      <= bus.pc_exe;
      r_alu_mem     <= w_alu_result;
      r_rs2_mem     <= bus.rs2_exe;
      r_instr_mem   <= bus.instr_exe;
      r_rd_addr_mem <= bus.rd_addr_exe;
    end
  end

  assign bus.pc_mem      = r_pc_mem;
  assign bus.alu_mem     = r_alu_mem;
  assign bus.rs2_mem     = r_rs2_mem;
  assign bus.instr_mem   = r_instr_mem;
  assign bus.rd_addr_mem = r_rd_addr_mem;

endmodule

// File: tb/tb_execute.sv
// Directed and randomized checks of the EXE stage against a behavioural model.
module tb_execute;
  import execute_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  execute_if u_if ();

  execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned s;
    logic [31:0] fill;
    s = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a * (32'd1 << s);
      4'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'd1 << s);
      4'd7:  return (a >> s) | fill;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sel_a(input logic [2:0] s);
    logic [31:0] t [8];
    t = '{u_if.rs1_exe, u_if.pc_exe, u_if.forward_mem, u_if.forward_wb, 0, 0, 0, 0};
    return t[s];
  endfunction

  function automatic logic [31:0] sel_b(input logic [2:0] s);
    logic [31:0] t [8];
    t = '{u_if.rs2_exe, u_if.imm_exe, 32'd4, u_if.forward_mem, u_if.forward_wb, 0, 0, 0};
    return t[s];
  endfunction

  task automatic load(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [31:0] instr, input logic [4:0] rd,
                      input logic [31:0] fm, input logic [31:0] fw);
    u_if.pc_exe      = pc;
    u_if.rs1_exe     = rs1;
    u_if.rs2_exe     = rs2;
    u_if.imm_exe     = imm;
    u_if.instr_exe   = instr;
    u_if.rd_addr_exe = rd;
    u_if.forward_mem = fm;
    u_if.forward_wb  = fw;
  endtask

  task automatic ops(input logic [2:0] as, input logic [2:0] bs, input logic [3:0] op);
    u_if.a_sel  = as;
    u_if.b_sel  = bs;
    u_if.alu_op = op;
  endtask

  task automatic rand_inputs();
    load($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
         $urandom, $urandom);
    ops(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc"},    u_if.pc_mem, 32'h0);
    chk({tag, ".alu"},   u_if.alu_mem, 32'h0);
    chk({tag, ".rs2"},   u_if.rs2_mem, 32'h0);
    chk({tag, ".instr"}, u_if.instr_mem, 32'h0);
    chk({tag, ".rd"},    {27'h0, u_if.rd_addr_mem}, 32'h0);
  endtask

  // Called at a negedge with inputs stable; checks what the next posedge captured.
  task automatic tick(input string tag, input logic [31:0] exp_alu);
    logic [31:0] e_pc, e_rs2, e_instr;
    logic [4:0]  e_rd;
    e_pc = u_if.pc_exe;
    e_rs2 = u_if.rs2_exe;
    e_instr = u_if.instr_exe;
    e_rd = u_if.rd_addr_exe;
    @(posedge clk);
    #1;
    chk({tag, ".alu"},   u_if.alu_mem, exp_alu);
    chk({tag, ".pc"},    u_if.pc_mem, e_pc);
    chk({tag, ".rs2"},   u_if.rs2_mem, e_rs2);
    chk({tag, ".instr"}, u_if.instr_mem, e_instr);
    chk({tag, ".rd"},    {27'h0, u_if.rd_addr_mem}, {27'h0, e_rd});
    @(negedge clk);
  endtask

  task automatic tick_model(input string tag);
    tick(tag, ref_alu(sel_a(u_if.a_sel), sel_b(u_if.b_sel), u_if.alu_op));
  endtask

  initial begin
    logic [2:0]  seq_b   [7];
    logic [31:0] seq_exp [7];
    seq_b   = '{3'd5, 3'd2, 3'd4, 3'd2, 3'd3, 3'd4, 3'd5};
    seq_exp = '{32'd0, 32'd4, 32'd7, 32'd4, 32'd6, 32'd7, 32'd0};

    rst_n = 1'b0;
    rand_inputs();
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_inputs();
      @(posedge clk);
      #1;
      chk_zero("rst_clocked");
    end
    @(negedge clk);
    rst_n = 1'b1;
    rand_inputs();
    tick_model("rst_release");

    load(32'd1, 32'd2, 32'd3, 32'd4, 32'h0000_0013, 5'd5, 32'd6, 32'd7);
    for (int i = 0; i < 7; i++) begin
      ops(3'd4, seq_b[i], 4'd0);
      tick($sformatf("bseq%0d", i), seq_exp[i]);
    end

    load(32'h40, 32'h7FFF_FFFF, 32'h55, 32'd1, 32'h0000_0033, 5'd9, 32'h0, 32'h0);
    ops(3'd0, 3'd1, 4'd0);
    tick("add_ovf", 32'h8000_0000);
    u_if.imm_exe = 32'h8000_0000;
    ops(3'd0, 3'd1, 4'd1);
    tick("sub_wrap", 32'hFFFF_FFFF);

    load(32'h44, 32'h8000_0000, 32'h66, 32'd4, 32'h4000_5033, 5'd10, 32'h0, 32'h0);
    ops(3'd0, 3'd1, 4'd7);
    tick("sra", 32'hF800_0000);
    ops(3'd0, 3'd1, 4'd6);
    tick("srl", 32'h0800_0000);
    u_if.imm_exe = 32'd33;
    ops(3'd0, 3'd1, 4'd2);
    tick("sll33", 32'h0000_0000);
    u_if.imm_exe = 32'd1;
    ops(3'd0, 3'd1, 4'd3);
    tick("slt", 32'h0000_0001);
    ops(3'd0, 3'd1, 4'd4);
    tick("sltu", 32'h0000_0000);

    load(32'h100, 32'h1, 32'h2, 32'hABC0_0000, 32'h0000_006F, 5'd1, 32'h3, 32'h4);
    ops(3'd1, 3'd2, 4'd0);
    tick("pc_plus4", 32'h0000_0104);
    ops(3'd1, 3'd1, 4'd10);
    tick("pass_b", 32'hABC0_0000);
    ops(3'd1, 3'd1, 4'd15);
    tick("op15", 32'h0000_0000);

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      tick_model($sformatf("rand%0d", i));
    end

    // Mid-operation reset between clock edges must clear outputs immediately.
    load(32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D, 32'h1, 32'hCAFE_0001, 5'd31, 32'h5, 32'h6);
    ops(3'd0, 3'd0, 4'd8);
    tick_model("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst_async");
    @(posedge clk);
    #1;
    chk_zero("mid_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    rand_inputs();
    tick_model("post_rst");
    rand_inputs();
    tick_model("post_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameters: none; widths come from shared constants XLEN=32, REG_DATA_WIDTH=32, REG_ADDR_WIDTH=5, A_SEL_WIDTH=3, B_SEL_WIDTH=3, ALU_OP_WIDTH=4.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pc_exe  in  32  PC of instruction in EXE.
REQ-006 rs1_exe / rs2_exe  in  32 each  register-file operands from ID/EXE.
REQ-007 instr_exe  in  32  instruction word in EXE.
REQ-008 imm_exe  in  32  sign-extended immediate.
REQ-009 a_sel  in  3  operand-A select; b_sel  in  3  operand-B select; alu_op  in  4  ALU operation.
REQ-010 rd_addr_exe  in  5  destination register of EXE instruction.
REQ-011 forward_mem  in  32  result forwarded from MEM stage; forward_wb  in  32  result forwarded from WB stage.
REQ-012 pc_mem, alu_mem, rs2_mem, instr_mem  out  32 each  EXE/MEM pipeline registers.
REQ-013 rd_addr_mem  out  5  registered destination register.

Function
REQ-014 a_sel encodings SHALL be: A_SEL_RS1=0 rs1_exe, A_SEL_PC=1 pc_exe, A_SEL_ALU=2 forward_mem, A_SEL_MEM=3 forward_wb, A_SEL_ZERO=4 constant 0; codes 5-7 select 0.
REQ-015 b_sel encodings SHALL be: B_SEL_RS2=0 rs2_exe, B_SEL_IMM=1 imm_exe, B_SEL_FOUR=2 constant 4, B_SEL_ALU=3 forward_mem, B_SEL_MEM=4 forward_wb, B_SEL_ZERO=5 constant 0; codes 6-7 select 0.
REQ-016 alu_op encodings SHALL be: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10; codes 11-15 yield 0.
REQ-017 Arithmetic SHALL be 32-bit modulo 2^32 (carry/overflow discarded); shifts use B[4:0] only; SLT signed, SLTU unsigned, result 1 or 0 zero-extended; SRA replicates bit 31.
REQ-018 Operand muxes and ALU SHALL be purely combinational within the cycle.
REQ-019 On each rising clk (rst_n high): alu_mem<=ALU result, pc_mem<=pc_exe, rs2_mem<=rs2_exe (unforwarded), instr_mem<=instr_exe, rd_addr_mem<=rd_addr_exe.
REQ-020 Latency SHALL be exactly one cycle from input change to registered output; no stall, flush or handshake; every edge captures.
REQ-021 Forwarding selection is fully decided externally via a_sel/b_sel; the block performs no hazard detection.

Reset
REQ-022 While rst_n low, all outputs (pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem) SHALL be 0, asynchronously, independent of clk.
REQ-023 Reset assertion mid-operation SHALL discard in-flight values; first edge after rst_n rises captures current inputs normally.

Structure
REQ-024 All widths, XLEN and the A_SEL_*, B_SEL_*, ALU_OP_* encodings SHALL live in the shared constants package/header, not in the module.
REQ-025 The ALU SHALL be a separate combinational sub-module named alu (inputs a, b, alu_op; output result); muxes and pipeline registers stay in execute.

Verification
REQ-026 Reset: rst_n=0 with arbitrary inputs and clock running -> all outputs 0; release -> next edge captures inputs.
REQ-027 pc_exe=1, rs1=2, rs2=3, imm=4, rd=5, fwd_mem=6, fwd_wb=7, a_sel=ZERO, alu_op=ADD; b_sel sequence ZERO,FOUR,MEM,FOUR,ALU,MEM,ZERO one per cycle -> alu_mem 0,4,7,4,6,7,0 each one cycle later; pc_mem=1, rs2_mem=3, rd_addr_mem=5 throughout.
REQ-028 a_sel=RS1 (0x7FFFFFFF), b_sel=IMM (1), ADD -> 0x80000000; SUB with B=0x80000000 -> 0xFFFFFFFF.
REQ-029 a=0x80000000, b=4: SRA -> 0xF8000000, SRL -> 0x08000000, SLL with b=33 -> 0x00000000 (shift by 1 of bit 31 -> 0); SLT(a,1)=1, SLTU(a,1)=0.
REQ-030 a_sel=PC (0x100), b_sel=FOUR, ADD -> alu_mem 0x104; PASS_B with b_sel=IMM 0xABC00000 -> 0xABC00000; alu_op=15 -> 0.
